// File: rtl/contador_modn_pkg.sv
// Shared constants and types for the contador_modn counter.
//   DEF_BITS / DEF_PRESC_BITS : default counter and prescaler widths
//   DIR_UP / DIR_DOWN         : encodings of the Up input
//   op_t                      : per-edge operation, in priority order
// Optional feature macro: CONTADOR_PRESCALER_EN (enables the prescaler_n stage).
package contador_modn_pkg;

    localparam int DEF_BITS       = 29;
    localparam int DEF_PRESC_BITS = 8;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_STEP  = 2'd1,
        OP_LOAD  = 2'd2,
        OP_CLEAR = 2'd3
    } op_t;

    // Clear > Load > step > hold
    function automatic op_t decode_op(input logic clear, input logic load, input logic step);
        if (clear)     return OP_CLEAR;
        else if (load) return OP_LOAD;
        else if (step) return OP_STEP;
        else           return OP_HOLD;
    endfunction

endpackage

// File: rtl/prescaler_n.sv
// Enabled-edge prescaler for contador_modn (built only with CONTADOR_PRESCALER_EN).
// Ports:
//   NEclk  in  clock, falling edge active
//   Nreset in  asynchronous active-low reset
//   Enable in  advance the phase counter; 0 freezes it and suppresses tick
//   Clear  in  synchronous return of the phase to 0 (counter Clear or Load)
//   Div    in  divide ratio: tick every Div+1 enabled edges
//   tick   out combinational: this enabled edge completes a prescaler period
module prescaler_n #(
    parameter int PRESC_BITS = 8
) (
    input  logic                  NEclk,
    input  logic                  Nreset,
    input  logic                  Enable,
    input  logic                  Clear,
    input  logic [PRESC_BITS-1:0] Div,
    output logic                  tick
);

    logic [PRESC_BITS-1:0] phase;

    // >= rather than == so that lowering Div below the current phase wraps
    // immediately instead of running the phase all the way round.
    assign tick = Enable && (phase >= Div);

    always_ff @(negedge NEclk or negedge Nreset) begin
        if (!Nreset) begin
            phase <= '0;
        end else if (Clear) begin
            phase <= '0;
        end else if (Enable) begin
            phase <= tick ? '0 : phase + 1'b1;
        end
    end

endmodule

// File: rtl/contador_modn.sv
// Modulo-N up/down counter with synchronous clear/load, terminal-count pulse
// and sticky wrap flag. All state changes on the falling edge of NEclk.
// Ports:
//   NEclk     in   clock, falling edge active
//   Nreset    in   asynchronous active-low reset
//   Enable    in   count enable (0 freezes count and prescaler)
//   Up        in   direction, DIR_UP=1 / DIR_DOWN=0
//   Clear     in   synchronous clear (highest priority)
//   Load      in   synchronous load of LoadValue, clamped to MAX_COUNT
//   LoadValue in   value for Load
//   PrescDiv  in   prescaler ratio (only used with CONTADOR_PRESCALER_EN)
//   count     out  registered count, 0..MAX_COUNT
//   tc        out  one-edge pulse on a wrap
//   wrapped   out  sticky wrap flag, cleared by Clear/Nreset
// Optional feature macro: CONTADOR_PRESCALER_EN. Undefined, every enabled
// edge steps (equivalent to PrescDiv=0).
module contador_modn
    import contador_modn_pkg::*;
#(
    parameter int          BITS       = DEF_BITS,
    parameter int unsigned MAX_COUNT  = (2**BITS)-1,
    parameter int          PRESC_BITS = DEF_PRESC_BITS
) (
    input  logic                  NEclk,
    input  logic                  Nreset,
    input  logic                  Enable,
    input  logic                  Up,
    input  logic                  Clear,
    input  logic                  Load,
    input  logic [BITS-1:0]       LoadValue,
    input  logic [PRESC_BITS-1:0] PrescDiv,
    output logic [BITS-1:0]       count,
    output logic                  tc,
    output logic                  wrapped
);

    generate
        if (longint'(MAX_COUNT) > (longint'(1) << BITS) - 1) begin : g_bad_max
            $error("contador_modn: MAX_COUNT does not fit in BITS");
        end
    endgenerate

    localparam logic [BITS-1:0] MAX_V = BITS'(MAX_COUNT);

    logic tick;

`ifdef CONTADOR_PRESCALER_EN
    // Load also restarts the prescaler phase.
    prescaler_n #(.PRESC_BITS(PRESC_BITS)) u_presc (
        .NEclk  (NEclk),
        .Nreset (Nreset),
        .Enable (Enable),
        .Clear  (Clear | Load),
        .Div    (PrescDiv),
        .tick   (tick)
    );
`else
    logic unused_presc;
    assign unused_presc = ^PrescDiv;
    assign tick         = 1'b1;
`endif

    op_t             op;
    logic [BITS-1:0] load_clamped;

    assign op           = decode_op(Clear, Load, Enable && tick);
    assign load_clamped = (LoadValue > MAX_V) ? MAX_V : LoadValue;

    always_ff @(negedge NEclk or negedge Nreset) begin
        if (!Nreset) begin
            count   <= '0;
            tc      <= 1'b0;
            wrapped <= 1'b0;
        end else begin
            tc <= 1'b0;
            case (op)
                OP_CLEAR: begin
                    count   <= '0;
                    wrapped <= 1'b0;
                end
                OP_LOAD: count <= load_clamped;
                OP_STEP: begin
                    if (Up == DIR_UP) begin
                        if (count >= MAX_V) begin
                            count   <= '0;
                            tc      <= 1'b1;
                            wrapped <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end else begin
                        if (count == '0) begin
                            count   <= MAX_V;
                            tc      <= 1'b1;
                            wrapped <= 1'b1;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
